// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bus: instruction-memory pair, redirect/stall controls and the
// two-slot decode handshake, grouped so the fetch unit sees one port.
interface fetch_queue_unit_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned QDEPTH = 8
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic [1:0][WIDTH-1:0] Program_counter_IM;
    logic [1:0][WIDTH-1:0] Instruction_IM;
    logic                  redirect_valid;
    logic [WIDTH-1:0]      redirect_pc;
    logic                  fetch_stall;
    logic                  dec_ready;
    logic [1:0]            dec_valid;
    logic [1:0][WIDTH-1:0] dec_instr;
    logic [1:0][WIDTH-1:0] dec_pc;
    logic [CW-1:0]         q_count;

    // Fetch unit side
    modport master (
        output Program_counter_IM,
        input  Instruction_IM,
        input  redirect_valid,
        input  redirect_pc,
        input  fetch_stall,
        input  dec_ready,
        output dec_valid,
        output dec_instr,
        output dec_pc,
        output q_count
    );

    // Memory / decode / redirect side
    modport slave (
        input  Program_counter_IM,
        output Instruction_IM,
        output redirect_valid,
        output redirect_pc,
        output fetch_stall,
        output dec_ready,
        input  dec_valid,
        input  dec_instr,
        input  dec_pc,
        input  q_count
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Dual-issue fetch stage: owns the PC, reads an instruction pair per cycle
// from a combinational memory and buffers it in a QDEPTH-entry queue whose
// two oldest entries are offered to decode. Redirect flushes everything.
module fetch_queue_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      QDEPTH   = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [WIDTH-1:0] pc_q, pc_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH-1:0] instr_mem [QDEPTH];
    logic [WIDTH-1:0] pc_mem    [QDEPTH];

    logic             fire;
    logic [1:0]       pop_n;
    logic [1:0]       valid;
    ptr_t             rd_ptr_nx;
    ptr_t             wr_ptr_nx;

    assign rd_ptr_nx = rd_ptr_q + ptr_t'(1);
    assign wr_ptr_nx = wr_ptr_q + ptr_t'(1);

    // Queue status and decode view of the two oldest entries
    always_comb begin
        valid[0] = (count_q != '0);
        valid[1] = (count_q >= CW'(2));
        // Pre-pop occupancy keeps this conservative: two free slots always exist
        fire     = !bus.redirect_valid && !bus.fetch_stall && (count_q <= CW'(QDEPTH - 2));
        pop_n    = bus.dec_ready ? ({1'b0, valid[0]} + {1'b0, valid[1]}) : 2'd0;
    end

    assign bus.Program_counter_IM[0] = pc_q;
    assign bus.Program_counter_IM[1] = pc_q + WIDTH'(4);
    assign bus.dec_valid             = valid;
    assign bus.dec_instr[0]          = instr_mem[rd_ptr_q];
    assign bus.dec_instr[1]          = instr_mem[rd_ptr_nx];
    assign bus.dec_pc[0]             = pc_mem[rd_ptr_q];
    assign bus.dec_pc[1]             = pc_mem[rd_ptr_nx];
    assign bus.q_count               = count_q;

    // Next PC, pointers and occupancy; redirect overrides push and pop
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect_valid) begin
            pc_d     = {bus.redirect_pc[WIDTH-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + ptr_t'(pop_n);
            count_d  = count_q - CW'(pop_n) + (fire ? CW'(2) : CW'(0));
            if (fire) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(2);
                pc_d     = pc_q + WIDTH'(8);
            end
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage, written in PC then PC+4 order; contents need no reset
    always_ff @(posedge clk) begin
        if (fire) begin
            instr_mem[wr_ptr_q]  <= bus.Instruction_IM[0];
            pc_mem[wr_ptr_q]     <= pc_q;
            instr_mem[wr_ptr_nx] <= bus.Instruction_IM[1];
            pc_mem[wr_ptr_nx]    <= pc_q + WIDTH'(4);
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: instruction memory returns address>>2; a
// scoreboard queue holds expected PCs in fetch order and is checked on pops.
module tb_fetch_queue_unit;
    logic clk;
    logic rst_n;

    fetch_queue_unit_if #(.WIDTH(32), .QDEPTH(8)) bus ();

    fetch_queue_unit #(
        .WIDTH   (32),
        .QDEPTH  (8),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    assign bus.Instruction_IM[0] = bus.Program_counter_IM[0] >> 2;
    assign bus.Instruction_IM[1] = bus.Program_counter_IM[1] >> 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] sb[$];
    logic [31:0] m_pc;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        stall;
        logic        ready;
        int          cycles;
        int          exp_count;
        logic [1:0]  exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Check outputs against the model, then advance model and DUT by one edge
    task automatic run_cycle();
        int          sz;
        int          npop;
        logic [31:0] e;
        sz = sb.size();
        chk("q_count", 32'(bus.q_count), 32'(sz));
        chk("dec_valid", 32'(bus.dec_valid), 32'({sz >= 2, sz >= 1}));
        chk("pc_im0", bus.Program_counter_IM[0], m_pc);
        chk("pc_im1", bus.Program_counter_IM[1], m_pc + 32'd4);
        npop = bus.dec_ready ? ((sz >= 2) ? 2 : sz) : 0;
        for (int k = 0; k < npop; k++) begin
            e = sb.pop_front();
            chk("dec_pc", bus.dec_pc[k], e);
            chk("dec_instr", bus.dec_instr[k], e >> 2);
        end
        if (bus.redirect_valid) begin
            sb.delete();
            m_pc = {bus.redirect_pc[31:2], 2'b00};
        end else if (!bus.fetch_stall && sz <= 6) begin
            sb.push_back(m_pc);
            sb.push_back(m_pc + 32'd4);
            m_pc = m_pc + 32'd8;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rv    rpc            stall ready cyc cnt valid  pc
        vecs[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 6,  8, 2'b11, 32'h20};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5,  6, 2'b11, 32'h40};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 3,  0, 2'b00, 32'h40};
        vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 3,  6, 2'b11, 32'h58};
        vecs[4]  = '{1'b1, 32'h103,       1'b0, 1'b1, 1,  0, 2'b00, 32'h100};
        vecs[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1,  2, 2'b11, 32'h108};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1,  0, 2'b00, 32'h108};
        vecs[7]  = '{1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1,  0, 2'b00, 32'hFFFF_FFF8};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1,  2, 2'b11, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 12, 2, 2'b11, 32'h60};
        vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 1,  0, 2'b00, 32'h60};

        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.fetch_stall    = 1'b1;
        bus.dec_ready      = 1'b0;
        m_pc               = 32'h0;
        #12;
        chk("rst_q_count", 32'(bus.q_count), 32'd0);
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_pc_im0", bus.Program_counter_IM[0], 32'h0);
        chk("rst_pc_im1", bus.Program_counter_IM[1], 32'h4);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc    = vecs[i].rpc;
            bus.fetch_stall    = vecs[i].stall;
            bus.dec_ready      = vecs[i].ready;
            for (int c = 0; c < vecs[i].cycles; c++) run_cycle();
            bus.redirect_valid = 1'b0;
            chk($sformatf("vec%0d_count", i), 32'(bus.q_count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_valid", i), 32'(bus.dec_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_pc", i), bus.Program_counter_IM[0], vecs[i].exp_pc);
        end

        // Asynchronous reset between edges while the queue holds data
        bus.fetch_stall = 1'b0;
        bus.dec_ready   = 1'b0;
        run_cycle();
        run_cycle();
        chk("pre_rst_count", 32'(bus.q_count), 32'd4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.dec_valid), 32'd0);
        chk("async_rst_count", 32'(bus.q_count), 32'd0);
        chk("async_rst_pc_im0", bus.Program_counter_IM[0], 32'h0);
        chk("async_rst_pc_im1", bus.Program_counter_IM[1], 32'h4);
        sb.delete();
        m_pc = 32'h0;
        #1;
        rst_n           = 1'b1;
        bus.fetch_stall = 1'b1;
        @(posedge clk);
        #1;

        // Resume with always-ready decode, then drain
        bus.fetch_stall = 1'b0;
        bus.dec_ready   = 1'b1;
        for (int c = 0; c < 4; c++) run_cycle();
        bus.fetch_stall = 1'b1;
        for (int c = 0; c < 2; c++) run_cycle();
        chk("final_count", 32'(bus.q_count), 32'd0);
        chk("final_pc", bus.Program_counter_IM[0], 32'h20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
